// File: rtl/gpr_hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the GPR hazard scoreboard: write-data select codes,
// forwarding select codes and the in-flight write slot record.
package gpr_hazard_scoreboard_pkg;

    localparam logic [1:0] WSEL_MEM = 2'b00;
    localparam logic [1:0] WSEL_ALU = 2'b01;
    localparam logic [1:0] WSEL_PC  = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [1:0] sel;
    } slot_t;

    // r0 is hard-wired zero, so it can never match a pending write.
    function automatic logic slot_hit(input slot_t s, input logic [4:0] a);
        return s.v && (s.rd == a) && (a != 5'd0);
    endfunction

endpackage

// File: rtl/gpr_hazard_scoreboard_fwd_select_enc.sv
// Per-source forwarding encoder: picks the youngest in-flight slot that writes the source
// register and flags a load still in EXE, whose data cannot be forwarded yet.
module fwd_select_enc
    import gpr_hazard_scoreboard_pkg::*;
(
    input  logic [4:0] src_addr,
    input  slot_t      exe_slot,
    input  slot_t      mem_slot,
    input  slot_t      wb_slot,
    output logic [1:0] fwd_sel,
    output logic       load_use
);

    // Priority encode youngest-first; a load in EXE is a hit that must stall.
    always_comb begin
        fwd_sel  = FWD_RF;
        load_use = 1'b0;
        if (slot_hit(exe_slot, src_addr)) begin
            fwd_sel  = FWD_EXE;
            load_use = (exe_slot.sel == WSEL_MEM);
        end else if (slot_hit(mem_slot, src_addr)) begin
            fwd_sel  = FWD_MEM;
        end else if (slot_hit(wb_slot, src_addr)) begin
            fwd_sel  = FWD_WB;
        end else begin
            fwd_sel  = FWD_RF;
        end
    end

endmodule

// File: rtl/gpr_hazard_scoreboard.sv
// Tracks in-flight GPR writes (EXE/MEM/WB plus one multi-cycle MDU write), drives the
// ID-stage operand forwarding selects and stalls ID on load-use and MDU hazards.
module gpr_hazard_scoreboard
    import gpr_hazard_scoreboard_pkg::*;
#(
    parameter int MDU_LATENCY = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs_addr,
    input  logic       id_rs_used,
    input  logic [4:0] id_rt_addr,
    input  logic       id_rt_used,
    input  logic       id_we,
    input  logic [4:0] id_rd,
    input  logic [1:0] id_wdata_select,
    input  logic       id_is_mdu,
    input  logic       pipe_stall_in,
    input  logic       flush,
    output logic       stall_id,
    output logic [1:0] rs_fwd_sel,
    output logic [1:0] rt_fwd_sel,
    output logic       mdu_busy,
    output logic       mdu_done,
    output logic [4:0] mdu_rd
);

    localparam int CNT_W = $clog2(MDU_LATENCY + 1);

    slot_t            exe_q, mem_q, wb_q;
    slot_t            exe_d, mem_d, wb_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [4:0]       mdu_rd_q, mdu_rd_d;

    logic             rs_load_use_s, rt_load_use_s;
    logic             mdu_raw_s, mdu_waw_s, mdu_struct_s;
    logic             issue_s, mdu_accept_s;

    fwd_select_enc u_rs_enc (
        .src_addr (id_rs_addr),
        .exe_slot (exe_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .fwd_sel  (rs_fwd_sel),
        .load_use (rs_load_use_s)
    );

    fwd_select_enc u_rt_enc (
        .src_addr (id_rt_addr),
        .exe_slot (exe_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .fwd_sel  (rt_fwd_sel),
        .load_use (rt_load_use_s)
    );

    assign mdu_busy = (mdu_cnt_q != {CNT_W{1'b0}});
    assign mdu_done = (mdu_cnt_q == CNT_W'(1));
    assign mdu_rd   = mdu_rd_q;

    // Hazard detection and stall decision; flush kills the ID instruction so it never stalls.
    always_comb begin
        mdu_raw_s    = mdu_busy &&
                       ((id_rs_used && (id_rs_addr != 5'd0) && (id_rs_addr == mdu_rd_q)) ||
                        (id_rt_used && (id_rt_addr != 5'd0) && (id_rt_addr == mdu_rd_q)));
        mdu_waw_s    = mdu_busy && id_we && (id_rd == mdu_rd_q);
        mdu_struct_s = mdu_busy && id_is_mdu;
        stall_id     = id_valid && !flush &&
                       ((rs_load_use_s && id_rs_used) || (rt_load_use_s && id_rt_used) ||
                        mdu_raw_s || mdu_waw_s || mdu_struct_s);
        issue_s      = id_valid && !stall_id && !flush && id_we && !id_is_mdu && (id_rd != 5'd0);
        mdu_accept_s = id_valid && id_is_mdu && id_we && !stall_id && !flush && (id_rd != 5'd0);
    end

    // Next state of the slot chain (frozen by pipe_stall_in) and the free-running MDU countdown.
    always_comb begin
        exe_d     = exe_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        mdu_cnt_d = mdu_cnt_q;
        mdu_rd_d  = mdu_rd_q;
        if (!pipe_stall_in) begin
            wb_d      = mem_q;
            mem_d     = exe_q;
            exe_d.v   = issue_s;
            exe_d.rd  = id_rd;
            exe_d.sel = id_wdata_select[1] ? WSEL_PC : id_wdata_select;
        end else begin
            exe_d     = exe_q;
        end
        if (mdu_accept_s) begin
            mdu_cnt_d = CNT_W'(MDU_LATENCY);
            mdu_rd_d  = id_rd;
        end else if (mdu_busy) begin
            mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
        end else begin
            mdu_cnt_d = {CNT_W{1'b0}};
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q     <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            mdu_cnt_q <= {CNT_W{1'b0}};
            mdu_rd_q  <= 5'd0;
        end else begin
            exe_q     <= exe_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            mdu_cnt_q <= mdu_cnt_d;
            mdu_rd_q  <= mdu_rd_d;
        end
    end

endmodule

// File: tb/tb_gpr_hazard_scoreboard.sv
// Directed self-checking bench for gpr_hazard_scoreboard (MDU_LATENCY = 8).
module tb_gpr_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs_addr;
    logic       id_rs_used;
    logic [4:0] id_rt_addr;
    logic       id_rt_used;
    logic       id_we;
    logic [4:0] id_rd;
    logic [1:0] id_wdata_select;
    logic       id_is_mdu;
    logic       pipe_stall_in;
    logic       flush;
    logic       stall_id;
    logic [1:0] rs_fwd_sel;
    logic [1:0] rt_fwd_sel;
    logic       mdu_busy;
    logic       mdu_done;
    logic [4:0] mdu_rd;

    int tests_run = 0;
    int tests_failed = 0;

    gpr_hazard_scoreboard #(.MDU_LATENCY(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs_addr      (id_rs_addr),
        .id_rs_used      (id_rs_used),
        .id_rt_addr      (id_rt_addr),
        .id_rt_used      (id_rt_used),
        .id_we           (id_we),
        .id_rd           (id_rd),
        .id_wdata_select (id_wdata_select),
        .id_is_mdu       (id_is_mdu),
        .pipe_stall_in   (pipe_stall_in),
        .flush           (flush),
        .stall_id        (stall_id),
        .rs_fwd_sel      (rs_fwd_sel),
        .rt_fwd_sel      (rt_fwd_sel),
        .mdu_busy        (mdu_busy),
        .mdu_done        (mdu_done),
        .mdu_rd          (mdu_rd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic we,
                         input logic [4:0] rd, input logic [1:0] wsel, input logic mdu);
        id_valid = v; id_rs_addr = rs; id_rs_used = rsu; id_rt_addr = rt; id_rt_used = rtu;
        id_we = we; id_rd = rd; id_wdata_select = wsel; id_is_mdu = mdu;
    endtask

    task automatic set_idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b01, 1'b0);
        pipe_stall_in = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drain(input int n);
        set_idle();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) tick();
        settle();
        tests_run++;
        if ({stall_id, rs_fwd_sel, rt_fwd_sel, mdu_busy, mdu_done, mdu_rd} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b required 0", {stall_id, rs_fwd_sel, rt_fwd_sel, mdu_busy, mdu_done, mdu_rd});
        end
        rst_n = 1'b1;
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 2'b01, 1'b0);
        settle();
        tests_run++;
        if (rs_fwd_sel !== 2'b00 || rt_fwd_sel !== 2'b00 || stall_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_empty_slots: rs=%b rt=%b stall=%b required 00 00 0", rs_fwd_sel, rt_fwd_sel, stall_id);
        end
    endtask

    task automatic test_alu_forward();
        logic [1:0] exp_sel [4];
        exp_sel[0] = 2'b01; exp_sel[1] = 2'b10; exp_sel[2] = 2'b11; exp_sel[3] = 2'b00;
        drain(4);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 2'b01, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            settle();
            tests_run++;
            if (rs_fwd_sel !== exp_sel[i] || stall_id !== 1'b0) begin
                tests_failed++;
                $display("FAIL alu_fwd_age%0d: rs_sel=%b stall=%b required %b 0", i, rs_fwd_sel, stall_id, exp_sel[i]);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        drain(4);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'b00, 1'b0);
        tick();
        // consumer reads rt=r5 and rs=r9 (its own destination) so a missing bubble shows up on rs
        drive(1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 1'b1, 5'd9, 2'b01, 1'b0);
        settle();
        tests_run++;
        if (stall_id !== 1'b1 || rt_fwd_sel !== 2'b01) begin
            tests_failed++;
            $display("FAIL load_use_stall: stall=%b rt_sel=%b required 1 01", stall_id, rt_fwd_sel);
        end
        tick();
        settle();
        tests_run++;
        if (stall_id !== 1'b0 || rt_fwd_sel !== 2'b10 || rs_fwd_sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL load_use_release: stall=%b rt_sel=%b rs_sel=%b required 0 10 00", stall_id, rt_fwd_sel, rs_fwd_sel);
        end
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 2'b01, 1'b0);
        settle();
        tests_run++;
        if (rs_fwd_sel !== 2'b11 || rt_fwd_sel !== 2'b01) begin
            tests_failed++;
            $display("FAIL load_use_after: rs_sel=%b rt_sel=%b required 11 01", rs_fwd_sel, rt_fwd_sel);
        end
    endtask

    task automatic test_mdu_raw();
        drain(4);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'b01, 1'b1);
        settle();
        tests_run++;
        if (mdu_busy !== 1'b0 || stall_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL mdu_issue: busy=%b stall=%b required 0 0", mdu_busy, stall_id);
        end
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b01, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            settle();
            tests_run++;
            if (c <= 8) begin
                if (stall_id !== 1'b1 || mdu_busy !== 1'b1 || mdu_rd !== 5'd7 || mdu_done !== (c == 8)) begin
                    tests_failed++;
                    $display("FAIL mdu_raw_c%0d: stall=%b busy=%b rd=%0d done=%b required 1 1 7 %b",
                             c, stall_id, mdu_busy, mdu_rd, mdu_done, (c == 8));
                end
            end else begin
                if (stall_id !== 1'b0 || mdu_busy !== 1'b0 || mdu_done !== 1'b0 || rs_fwd_sel !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL mdu_raw_release: stall=%b busy=%b done=%b rs_sel=%b required 0 0 0 00",
                             stall_id, mdu_busy, mdu_done, rs_fwd_sel);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        drain(12);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'b01, 1'b1);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 2'b01, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            settle();
            tests_run++;
            if (stall_id !== (c <= 8)) begin
                tests_failed++;
                $display("FAIL mdu_struct_c%0d: stall=%b required %b", c, stall_id, (c <= 8));
            end
            tick();
        end
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 2'b01, 1'b0);
        settle();
        tests_run++;
        if (stall_id !== 1'b1 || mdu_busy !== 1'b1 || mdu_rd !== 5'd8) begin
            tests_failed++;
            $display("FAIL mdu_waw: stall=%b busy=%b rd=%0d required 1 1 8", stall_id, mdu_busy, mdu_rd);
        end
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 2'b01, 1'b0);
        settle();
        tests_run++;
        if (stall_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL mdu_no_waw: stall=%b required 0", stall_id);
        end
        drain(12);
    endtask

    task automatic test_pipe_stall();
        drain(4);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'b01, 1'b1);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 2'b01, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b01, 1'b0);
        pipe_stall_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            tests_run++;
            if (rs_fwd_sel !== 2'b01) begin
                tests_failed++;
                $display("FAIL freeze_hold_c%0d: rs_sel=%b required 01", c, rs_fwd_sel);
            end
            tick();
        end
        pipe_stall_in = 1'b0;
        settle();
        tests_run++;
        if (rs_fwd_sel !== 2'b01 || mdu_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL freeze_release: rs_sel=%b done=%b required 01 0", rs_fwd_sel, mdu_done);
        end
        repeat (3) tick();
        settle();
        tests_run++;
        if (mdu_done !== 1'b1 || rs_fwd_sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL freeze_mdu_count: done=%b rs_sel=%b required 1 00", mdu_done, rs_fwd_sel);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        drain(4);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 2'b01, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 2'b01, 1'b1);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 2'b01, 1'b0);
        settle();
        tests_run++;
        if (rs_fwd_sel !== 2'b00 || rt_fwd_sel !== 2'b00 || stall_id !== 1'b0 || mdu_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_reg: rs=%b rt=%b stall=%b busy=%b required 00 00 0 0",
                     rs_fwd_sel, rt_fwd_sel, stall_id, mdu_busy);
        end
    endtask

    task automatic test_flush_and_reset();
        drain(4);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'b00, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 2'b00, 1'b0);
        flush = 1'b1;
        settle();
        tests_run++;
        if (stall_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_stall: stall=%b required 0", stall_id);
        end
        tick();
        flush = 1'b0;
        drive(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 2'b01, 1'b0);
        settle();
        tests_run++;
        if (rs_fwd_sel !== 2'b00 || rt_fwd_sel !== 2'b10) begin
            tests_failed++;
            $display("FAIL flush_bubble: rs=%b rt=%b required 00 10", rs_fwd_sel, rt_fwd_sel);
        end
        drain(4);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'b01, 1'b1);
        tick();
        set_idle();
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mdu_busy !== 1'b0 || mdu_done !== 1'b0 || mdu_rd !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_mdu: busy=%b done=%b rd=%0d required 0 0 0", mdu_busy, mdu_done, mdu_rd);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            tests_run++;
            if (mdu_done !== 1'b0 || mdu_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_no_done_c%0d: done=%b busy=%b required 0 0", c, mdu_done, mdu_busy);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_mdu_raw();
        test_back_to_back();
        test_pipe_stall();
        test_zero_reg();
        test_flush_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
